// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package imem_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WR,
        CSUM,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs stream bytes into little-endian words and keeps a running XOR.
module word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic [7:0]  csum,
    output logic        word_full
);

    logic [1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 2'd0;
            word  <= 32'd0;
            csum  <= 8'd0;
        end else if (clear) begin
            count <= 2'd0;
            word  <= 32'd0;
            csum  <= 8'd0;
        end else if (shift) begin
            count <= count + 2'd1;
            word  <= {data, word[31:8]};
            csum  <= csum ^ data;
        end
    end

    // High while the next shifted byte completes the word.
    assign word_full = (count == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader that fills instruction memory and gates the core.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [15:0] DEPTH_N = 16'(DEPTH_WORDS);

    state_t state;
    state_t state_next;

    logic [15:0]       len;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       n_words;
    logic              accept;
    logic              bad_len;
    logic              last_word;
    logic              shift;
    logic              clear;
    logic              word_full;
    logic [7:0]        csum;

    assign accept    = in_valid && in_ready;
    assign n_words   = {in_data, len[7:0]};
    assign bad_len   = (n_words == 16'd0) || (n_words > DEPTH_N);
    assign last_word = (16'(addr) == len - 16'd1);
    assign shift     = accept && (state == DATA);
    assign clear     = accept && (state == LEN_HI);

    word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .shift     (shift),
        .data      (in_data),
        .word      (imem_wdata),
        .csum      (csum),
        .word_full (word_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            len   <= 16'd0;
            addr  <= '0;
        end else begin
            state <= state_next;
            if (accept && state == LEN_LO) begin
                len[7:0] <= in_data;
            end
            if (accept && state == LEN_HI) begin
                len[15:8] <= in_data;
                addr      <= '0;
            end
            if (state == WR) begin
                addr <= addr + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE, ERR: begin
                if (accept && in_data == SYNC_BYTE) state_next = LEN_LO;
            end
            LEN_LO: begin
                if (accept) state_next = LEN_HI;
            end
            LEN_HI: begin
                if (accept) state_next = bad_len ? ERR : DATA;
            end
            DATA: begin
                if (accept && word_full) state_next = WR;
            end
            WR: begin
                state_next = last_word ? CSUM : DATA;
            end
            CSUM: begin
                if (accept) state_next = (in_data == csum) ? DONE : ERR;
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready   = (state != WR);
    assign imem_we    = (state == WR);
    assign imem_waddr = addr;
    assign cpu_hold   = (state != DONE);
    assign done       = (state == DONE);
    assign error      = (state == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames, checksum, length limits, reset.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [5:0]  wa [0:31];
    logic [31:0] wd [0:31];
    int          nw = 0;

    logic [7:0] q[$];

    imem_loader #(.DEPTH_WORDS(64), .ADDR_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_we && nw < 32) begin
            wa[nw] <= imem_waddr;
            wd[nw] <= imem_wdata;
            nw     <= nw + 1;
        end
    end

    // The write cycle must never accept a byte.
    always @(negedge clk) begin
        if (imem_we) begin
            checks++;
            assert (in_ready === 1'b0) else begin
                errors++;
                $error("FAIL wr_ready: got %b expected 0", in_ready);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send_byte(s[i]);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hold"},  32'(cpu_hold),   32'd1);
        chk({tag, "_done"},  32'(done),       32'd0);
        chk({tag, "_err"},   32'(error),      32'd0);
        chk({tag, "_we"},    32'(imem_we),    32'd0);
        chk({tag, "_addr"},  32'(imem_waddr), 32'd0);
        chk({tag, "_wdata"}, imem_wdata,      32'd0);
        chk({tag, "_ready"}, 32'(in_ready),   32'd1);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;
        chk_reset_vals("rst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_vals("rst_rel");

        // Frame A: payload XOR is 13^93^10 = 90.
        q = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        send_seq(q);
        chk("a_we_timing", 32'(imem_we), 32'd1);
        chk("a_we_addr", 32'(imem_waddr), 32'd0);
        chk("a_we_data", imem_wdata, 32'h0000_0013);
        q = {8'h93, 8'h00, 8'h10, 8'h00};
        send_seq(q);
        chk("a_hold_csum", 32'(cpu_hold), 32'd1);
        send_byte(8'h90);
        idle();
        chk("a_nw", 32'(nw), 32'd2);
        chk("a_wa0", 32'(wa[0]), 32'd0);
        chk("a_wd0", wd[0], 32'h0000_0013);
        chk("a_wa1", 32'(wa[1]), 32'd1);
        chk("a_wd1", wd[1], 32'h0010_0093);
        chk("a_done", 32'(done), 32'd1);
        chk("a_hold", 32'(cpu_hold), 32'd0);
        chk("a_err", 32'(error), 32'd0);

        // Same frame, bad checksum.
        send_byte(8'hA5);
        idle();
        chk("b_hold_sync", 32'(cpu_hold), 32'd1);
        chk("b_done_sync", 32'(done), 32'd0);
        q = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, 8'h81};
        send_seq(q);
        idle();
        chk("b_nw", 32'(nw), 32'd4);
        chk("b_wd2", wd[2], 32'h0000_0013);
        chk("b_wd3", wd[3], 32'h0010_0093);
        chk("b_err", 32'(error), 32'd1);
        chk("b_hold", 32'(cpu_hold), 32'd1);
        chk("b_done", 32'(done), 32'd0);

        // Zero length.
        send_byte(8'hA5);
        chk("z_err_mid", 32'(error), 32'd0);
        q = {8'h00, 8'h00};
        send_seq(q);
        idle();
        chk("z_err", 32'(error), 32'd1);
        chk("z_nw", 32'(nw), 32'd4);

        // Length 65 exceeds depth.
        q = {8'hA5, 8'h41};
        send_seq(q);
        chk("o_err_mid", 32'(error), 32'd0);
        send_byte(8'h00);
        idle();
        chk("o_err", 32'(error), 32'd1);
        chk("o_nw", 32'(nw), 32'd4);

        // Junk is discarded; in-frame A5 is data.
        q = {8'h00, 8'hFF, 8'h5A};
        send_seq(q);
        idle();
        chk("j_err", 32'(error), 32'd1);
        chk("j_nw", 32'(nw), 32'd4);
        q = {8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
        send_seq(q);
        idle();
        chk("j_nw2", 32'(nw), 32'd5);
        chk("j_wa", 32'(wa[4]), 32'd0);
        chk("j_wd", wd[4], 32'hA5A5_A5A5);
        chk("j_done", 32'(done), 32'd1);

        // Reset during the third payload byte.
        q = {8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        send_seq(q);
        in_data = 8'h33;
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("mid");
        idle();
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_reset_vals("mid_rel");
        // 44^33^22^11 = 44.
        q = {8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
        send_seq(q);
        idle();
        chk("r_nw", 32'(nw), 32'd6);
        chk("r_wa", 32'(wa[5]), 32'd0);
        chk("r_wd", wd[5], 32'h1122_3344);
        chk("r_done", 32'(done), 32'd1);

        // Reload from DONE with valid held high; XOR of 01..08 = 08.
        send_byte(8'hA5);
        chk("h_hold", 32'(cpu_hold), 32'd1);
        chk("h_done", 32'(done), 32'd0);
        q = {8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
             8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
        send_seq(q);
        idle();
        chk("h_nw", 32'(nw), 32'd8);
        chk("h_wa0", 32'(wa[6]), 32'd0);
        chk("h_wd0", wd[6], 32'h0403_0201);
        chk("h_wa1", 32'(wa[7]), 32'd1);
        chk("h_wd1", wd[7], 32'h0807_0605);
        chk("h_done2", 32'(done), 32'd1);
        chk("h_hold2", 32'(cpu_hold), 32'd0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
